seg7_scan_decoder: RTL

Monitors a multiplexed, scanned 7-segment display bus (active-low digit selects plus active-low segment lines) and recovers the hexadecimal value shown on each digit. It is the inverse of the board's hex-to-segment encoding path. It sits beside the display driver as a readback/self-check block, and also serves as a front end for capturing external 7-segment displays. Each input pair is synchronised, debounced for stability, decoded, and stored per digit, with valid/error flags and a one-cycle update strobe.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_pat_dec.sv | 23 ++
 rtl/seg7_scan_decoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit order g..a),
// the blank pattern and the scan-decoder FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0011000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SETTLE = 1'b0,
        ARMED  = 1'b1
    } state_t;

    // Same table the encode path uses, so decode is its exact inverse.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_encode = SEG_0;
            4'h1:    seg_encode = SEG_1;
            4'h2:    seg_encode = SEG_2;
            4'h3:    seg_encode = SEG_3;
            4'h4:    seg_encode = SEG_4;
            4'h5:    seg_encode = SEG_5;
            4'h6:    seg_encode = SEG_6;
            4'h7:    seg_encode = SEG_7;
            4'h8:    seg_encode = SEG_8;
            4'h9:    seg_encode = SEG_9;
            4'hA:    seg_encode = SEG_A;
            4'hB:    seg_encode = SEG_B;
            4'hC:    seg_encode = SEG_C;
            4'hD:    seg_encode = SEG_D;
            4'hE:    seg_encode = SEG_E;
            default: seg_encode = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pat_dec.sv
// Combinational segment pattern decoder: legal hex code, blank, or neither.
module seg7_pat_dec
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nib
);

    always_comb begin
        hit   = 1'b0;
        nib   = 4'h0;
        blank = (pat == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pat == seg_encode(4'(i))) begin
                hit = 1'b1;
                nib = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit hex values from a scanned active-low 7-segment bus,
// with synchronisation, stability debounce and per-digit valid/error flags.
//
// state  | meaning
// SETTLE | counting consecutive identical samples toward a commit
// ARMED  | current sample already committed; waiting for the bus to change
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [NUM_DIG-1:0]     iSEL,
    input  logic [6:0]             iSEG,
    output logic [4*NUM_DIG-1:0]   oDIG,
    output logic [NUM_DIG-1:0]     oVALID,
    output logic [NUM_DIG-1:0]     oERR,
    output logic                   oUPD,
    output logic [2:0]             oUPD_IDX
);

    localparam int W  = NUM_DIG + 7;
    localparam int CW = $clog2(STABLE_CYC) + 1;

    logic [W-1:0]       sync1, sync2, prev;
    logic [CW-1:0]      cnt;
    state_t             state;
    logic [NUM_DIG-1:0] sel_low;
    logic               one_hot;
    logic [2:0]         idx;
    logic               hit, blank;
    logic [3:0]         nib;

    assign sel_low = ~sync2[W-1:7];
    assign one_hot = ($countones(sel_low) == 1);

    always_comb begin
        idx = 3'd0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (sel_low[k]) idx = 3'(k);
        end
    end

    seg7_pat_dec u_pat_dec (
        .pat   (sync2[6:0]),
        .hit   (hit),
        .blank (blank),
        .nib   (nib)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            sync1    <= '1;
            sync2    <= '1;
            prev     <= '1;
            cnt      <= '0;
            state    <= SETTLE;
            oDIG     <= '0;
            oVALID   <= '0;
            oERR     <= '0;
            oUPD     <= 1'b0;
            oUPD_IDX <= 3'd0;
        end else begin
            sync1 <= {iSEL, iSEG};
            sync2 <= sync1;
            prev  <= sync2;
            oUPD  <= 1'b0;
            case (state)
                SETTLE: begin
                    if (sync2 != prev) begin
                        cnt <= '0;
                    end else if (cnt == CW'(STABLE_CYC - 1)) begin
                        // Unqualified selects still arm, so one blanking
                        // window cannot be retried into a commit later.
                        state <= ARMED;
                        if (one_hot) begin
                            oUPD     <= 1'b1;
                            oUPD_IDX <= idx;
                            for (int k = 0; k < NUM_DIG; k++) begin
                                if (sel_low[k]) begin
                                    if (hit) begin
                                        oDIG[4*k +: 4] <= nib;
                                        oVALID[k]      <= 1'b1;
                                        oERR[k]        <= 1'b0;
                                    end else begin
                                        oVALID[k] <= 1'b0;
                                        oERR[k]   <= !blank;
                                    end
                                end
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ARMED: begin
                    if (sync2 != prev) begin
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= SETTLE;
                end
            endcase
        end
    end

endmodule
